mem1port_initiator: RTL and testbench
=====================================

Name: mem1port_initiator

Overview:
- Bus initiator for the single-port memory interface: ready, we, word address [31:2], wstrb, wdata, rresp, rdata.
- Accepts byte-addressed load/store requests from a core-side valid/ready port.
- Converts each request into one or two word-aligned bus beats. Generates write strobes and byte-lane shifting.
- Returns load data size-extended.
- Sits between a core LSU or a testbench driver and the single-port memory model.

Parameters:
- ALLOW_MISALIGN, 1: 1 = a misaligned access is split into two beats; 0 = it is rejected with resp_err and causes no bus activity.

Ports:
- clk  input  1  clock
- resetb  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_signed  input  1  sign-extend load data
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse for loads and stores
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  misaligned access rejected; valid with resp_valid
- mem_ready  output  1  bus beat strobe
- mem_we  output  1  beat is a write
- mem_addr  output  30  word address [31:2]
- mem_wdata  output  32  lane-positioned write data
- mem_wstrb  output  4  byte strobes
- mem_rresp  input  1  read data valid; arrives one cycle after a read beat
- mem_rdata  input  32  read data

Behaviour:
- Decided: one clock `clk`; reset `resetb` is asynchronous and active-low.
- Reset values: req_ready=1; resp_valid, resp_err, mem_ready and mem_we = 0; resp_rdata, mem_addr, mem_wdata and mem_wstrb = 0. FSM goes to IDLE.
- All outputs are registered.
- FSM states: IDLE, BEAT2, RWAIT1, RWAIT2, RESP.
- req_ready=1 only in IDLE. The request is captured at acceptance (cycle T).
- Offset: off = addr[1:0]; nbytes = 1/2/4. The access is split when off + nbytes > 4 (half at off 3; word at off 1–3). A byte access never splits.
- Lane math:
  - 64-bit data = req_wdata << 8*off; 8-bit mask = ((1<<nbytes)-1) << off.
  - Beat 1 uses word addr[31:2] with the low halves; beat 2 uses addr[31:2]+1 with the high halves.
  - mem_addr increments mod 2^30, so 0xFFFFFFFF wraps to word 0.
- Aligned store: beat at T+1 (mem_ready=1, mem_we=1); resp_valid at T+2.
- Split store: beats at T+1 and T+2; resp_valid at T+3.
- Aligned load:
  - T+1: beat with mem_we=0, mem_wstrb=0.
  - T+2: mem_rresp arrives.
  - T+3: resp_valid.
- Split load: beats back-to-back at T+1 and T+2; mem_rresp at T+2 and T+3, captured in order; resp_valid at T+4.
- Load data: result = ({second, first} >> 8*off), truncated to nbytes, then sign- or zero-extended.
- mem_ready is held high only for exactly one cycle per beat.
- The FSM stays in RWAIT until the expected mem_rresp arrives; no timeout.
- mem_rresp received in IDLE, in store states, or beyond the expected count is ignored.
- Misaligned request with ALLOW_MISALIGN=0: no beats; resp_valid=1 and resp_err=1 at T+1; resp_rdata=0.
- resp_valid lasts one cycle. The FSM is back in IDLE that same cycle, with req_ready=1, so a new request can be accepted in the resp_valid cycle.
- Reset asserted mid-operation: the transaction is abandoned and all outputs take reset values immediately. No response is ever issued for it, and a late mem_rresp is ignored.

Test Plan:
1. Memory word0=0x44332211, word1=0x88776655; load word at 0x0 -> mem_ready at T+1 with mem_addr=0, mem_we=0; resp_valid at T+3 with resp_rdata=0x44332211, resp_err=0.
2. Load byte at 0x7: signed -> 0xFFFFFF88; unsigned -> 0x00000088. Load half at 0x2, signed -> 0x00004433.
3. Load word at 0x2 -> beats at T+1 (mem_addr=0) and T+2 (mem_addr=1); resp_valid at T+4 with resp_rdata=0x66554433.
4. Store half 0xBEEF at 0x3 -> beat 1: mem_addr=0, wstrb=1000, wdata=0xEF000000; beat 2: mem_addr=1, wstrb=0001, wdata=0x000000BE; resp_valid at T+3. Subsequent word loads return 0xEF332211 and 0x887766BE.
5. ALLOW_MISALIGN=0, load word at 0x1 -> resp_valid=1 and resp_err=1 at T+1; mem_ready stays 0 throughout.
6. Split load at 0x2, resetb pulsed low at T+2 -> all outputs 0 during reset; req_ready=1 after release; the late mem_rresp produces no resp_valid; the next aligned load completes normally.

Source files
------------

// File: rtl/mem1port_initiator.sv
// rtl/mem1port_initiator.sv - byte-addressed load/store to word-bus initiator
// Splits misaligned accesses into two beats, lane-shifts store data, size-extends load data.
module mem1port_initiator #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ready,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rresp,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, BEAT2, RWAIT1, RWAIT2, RESP} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  nbytes_q;
    logic        signed_q;
    logic        we_q;
    logic        split_q;
    logic [31:0] first_q;
    logic [31:0] hi_wdata_q;
    logic [3:0]  hi_wstrb_q;

    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic        split;
    logic [63:0] lane_data;
    logic [7:0]  lane_mask;
    logic [55:0] rd_pair;
    logic [31:0] rd_low;
    logic [31:0] load_ext;

    always_comb begin
        off = req_addr[1:0];
        case (req_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        split = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
        lane_data = {32'b0, req_wdata} << {off, 3'b000};
        case (nbytes)
            3'd1:    lane_mask = 8'h01 << off;
            3'd2:    lane_mask = 8'h03 << off;
            default: lane_mask = 8'h0F << off;
        endcase
    end

    // Only bytes up to offset 3 + 4 are ever selected, so the top byte of the second word is never needed.
    always_comb begin
        if (state == RWAIT2)
            rd_pair = {mem_rdata[23:0], first_q};
        else
            rd_pair = {24'b0, mem_rdata};
        rd_low = rd_pair[{off_q, 3'b000} +: 32];
        case (nbytes_q)
            3'd1:    load_ext = {{24{signed_q & rd_low[7]}}, rd_low[7:0]};
            3'd2:    load_ext = {{16{signed_q & rd_low[15]}}, rd_low[15:0]};
            default: load_ext = rd_low;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
            mem_ready  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 30'b0;
            mem_wdata  <= 32'b0;
            mem_wstrb  <= 4'b0;
            off_q      <= 2'b0;
            nbytes_q   <= 3'd4;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            split_q    <= 1'b0;
            first_q    <= 32'b0;
            hi_wdata_q <= 32'b0;
            hi_wstrb_q <= 4'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_ready  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        off_q    <= off;
                        nbytes_q <= nbytes;
                        signed_q <= req_signed;
                        we_q     <= req_we;
                        split_q  <= split;
                        if (split && !ALLOW_MISALIGN) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'b0;
                        end else begin
                            req_ready  <= 1'b0;
                            mem_ready  <= 1'b1;
                            mem_we     <= req_we;
                            mem_addr   <= req_addr[31:2];
                            mem_wdata  <= req_we ? lane_data[31:0] : 32'b0;
                            mem_wstrb  <= req_we ? lane_mask[3:0] : 4'b0;
                            hi_wdata_q <= req_we ? lane_data[63:32] : 32'b0;
                            hi_wstrb_q <= req_we ? lane_mask[7:4] : 4'b0;
                            if (split)
                                state <= BEAT2;
                            else if (req_we)
                                state <= RESP;
                            else
                                state <= RWAIT1;
                        end
                    end
                end
                BEAT2: begin
                    mem_ready <= 1'b1;
                    mem_we    <= we_q;
                    mem_addr  <= mem_addr + 30'd1;
                    mem_wdata <= hi_wdata_q;
                    mem_wstrb <= hi_wstrb_q;
                    state     <= we_q ? RESP : RWAIT1;
                end
                RWAIT1: begin
                    if (mem_rresp) begin
                        if (split_q) begin
                            first_q <= mem_rdata;
                            state   <= RWAIT2;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= load_ext;
                            req_ready  <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                RWAIT2: begin
                    if (mem_rresp) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem1port_initiator.sv
// tb/tb_mem1port_initiator.sv - directed self-checking bench for mem1port_initiator
// Instance a allows misaligned splits against a word memory model; instance b rejects them.
module tb_mem1port_initiator;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [1:0]  req_size = 2'd2;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'b0;

    logic        req_ready, resp_valid, resp_err, mem_ready, mem_we, mem_rresp;
    logic [31:0] resp_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        req_ready_b, resp_valid_b, resp_err_b, mem_ready_b, mem_we_b;
    logic [31:0] resp_rdata_b, mem_wdata_b;
    logic [29:0] mem_addr_b;
    logic [3:0]  mem_wstrb_b;

    logic        model_rresp = 1'b0;
    logic [31:0] model_rdata = 32'b0;
    logic        extra_rresp = 1'b0;
    logic        mem_init = 1'b1;
    logic [31:0] mem [0:15];

    int total = 0;
    int bad = 0;

    logic        c_mrdy [0:10];
    logic        c_we   [0:10];
    logic        c_rv   [0:10];
    logic        c_err  [0:10];
    logic        c_rdy  [0:10];
    logic [29:0] c_addr [0:10];
    logic [31:0] c_wdata[0:10];
    logic [3:0]  c_wstrb[0:10];
    logic [31:0] c_rdata[0:10];
    logic        c_mrdyb[0:10];
    logic        c_rvb  [0:10];
    logic        c_errb [0:10];
    logic [31:0] c_rdatab[0:10];

    assign mem_rresp = model_rresp | extra_rresp;

    always #5 clk = ~clk;

    mem1port_initiator #(.ALLOW_MISALIGN(1'b1)) dut_a (
        .clk(clk), .resetb(resetb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rresp(mem_rresp), .mem_rdata(model_rdata)
    );

    mem1port_initiator #(.ALLOW_MISALIGN(1'b0)) dut_b (
        .clk(clk), .resetb(resetb),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_ready(mem_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .mem_rresp(1'b0), .mem_rdata(32'b0)
    );

    // Word memory: answers a read beat with rresp one cycle later, applies strobed writes.
    always @(posedge clk) begin
        model_rresp <= 1'b0;
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'b0;
            mem[0]  <= 32'h44332211;
            mem[1]  <= 32'h88776655;
            mem[15] <= 32'hAABBCCDD;
        end else if (mem_ready) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                model_rresp <= 1'b1;
                model_rdata <= mem[mem_addr[3:0]];
            end
        end
    end

    task automatic do_req(input bit to_b, input bit we, input logic [31:0] addr,
                          input logic [1:0] size, input bit sgn, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
        if (to_b) req_valid_b = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_valid_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            c_mrdy[k] = mem_ready; c_we[k] = mem_we; c_rv[k] = resp_valid; c_err[k] = resp_err;
            c_rdy[k] = req_ready; c_addr[k] = mem_addr; c_wdata[k] = mem_wdata;
            c_wstrb[k] = mem_wstrb; c_rdata[k] = resp_rdata;
            c_mrdyb[k] = mem_ready_b; c_rvb[k] = resp_valid_b; c_errb[k] = resp_err_b;
            c_rdatab[k] = resp_rdata_b;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err, mem_ready, mem_we} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=10000", {req_ready, resp_valid, resp_err, mem_ready, mem_we});
        end
        total++;
        if ({resp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 98'b0) begin
            bad++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h wstrb=%h", resp_rdata, mem_addr, mem_wdata, mem_wstrb);
        end
        mem_init = 1'b0;
        resetb = 1'b1;
    endtask

    task automatic test_aligned_load;
        do_req(0, 0, 32'h0, 2'd2, 0, 32'h0);
        total++;
        if ({c_mrdy[1], c_we[1], c_addr[1], c_wstrb[1]} !== {1'b1, 1'b0, 30'h0, 4'h0}) begin
            bad++; $display("FAIL ald_beat got rdy=%b we=%b addr=%h strb=%h want 1 0 0 0", c_mrdy[1], c_we[1], c_addr[1], c_wstrb[1]);
        end
        total++;
        if ({c_mrdy[2], c_rv[2], c_rdy[1]} !== 3'b000) begin
            bad++; $display("FAIL ald_t2 got mrdy=%b rv=%b rdy1=%b want 000", c_mrdy[2], c_rv[2], c_rdy[1]);
        end
        total++;
        if ({c_rv[3], c_err[3], c_rdy[3], c_rdata[3]} !== {3'b101, 32'h44332211}) begin
            bad++; $display("FAIL ald_resp got rv=%b err=%b rdy=%b data=%h want 1 0 1 44332211", c_rv[3], c_err[3], c_rdy[3], c_rdata[3]);
        end
        total++;
        if (c_rv[4] !== 1'b0) begin
            bad++; $display("FAIL ald_pulse got rv4=%b want 0", c_rv[4]);
        end
    endtask

    task automatic test_byte_half_load;
        do_req(0, 0, 32'h7, 2'd0, 1, 32'h0);
        total++;
        if ({c_addr[1], c_rv[3], c_rdata[3]} !== {30'h1, 1'b1, 32'hFFFFFF88}) begin
            bad++; $display("FAIL lb_signed got addr=%h rv=%b data=%h want 1 1 ffffff88", c_addr[1], c_rv[3], c_rdata[3]);
        end
        do_req(0, 0, 32'h7, 2'd0, 0, 32'h0);
        total++;
        if ({c_rv[3], c_rdata[3]} !== {1'b1, 32'h00000088}) begin
            bad++; $display("FAIL lb_unsigned got rv=%b data=%h want 1 00000088", c_rv[3], c_rdata[3]);
        end
        do_req(0, 0, 32'h2, 2'd1, 1, 32'h0);
        total++;
        if ({c_mrdy[2], c_rv[3], c_rdata[3]} !== {2'b01, 32'h00004433}) begin
            bad++; $display("FAIL lh_signed got mrdy2=%b rv=%b data=%h want 0 1 00004433", c_mrdy[2], c_rv[3], c_rdata[3]);
        end
    endtask

    task automatic test_split_load;
        do_req(0, 0, 32'h2, 2'd2, 0, 32'h0);
        total++;
        if ({c_mrdy[1], c_addr[1], c_mrdy[2], c_addr[2], c_mrdy[3]} !== {1'b1, 30'h0, 1'b1, 30'h1, 1'b0}) begin
            bad++; $display("FAIL sld_beats got %b/%h %b/%h %b want 1/0 1/1 0", c_mrdy[1], c_addr[1], c_mrdy[2], c_addr[2], c_mrdy[3]);
        end
        total++;
        if ({c_rv[3], c_rv[4], c_rdata[4]} !== {2'b01, 32'h66554433}) begin
            bad++; $display("FAIL sld_resp got rv3=%b rv4=%b data=%h want 0 1 66554433", c_rv[3], c_rv[4], c_rdata[4]);
        end
    endtask

    task automatic test_addr_wrap;
        do_req(0, 0, 32'hFFFFFFFF, 2'd1, 0, 32'h0);
        total++;
        if ({c_addr[1], c_addr[2], c_mrdy[2]} !== {30'h3FFFFFFF, 30'h0, 1'b1}) begin
            bad++; $display("FAIL wrap_addr got a1=%h a2=%h mrdy2=%b want 3fffffff 0 1", c_addr[1], c_addr[2], c_mrdy[2]);
        end
        total++;
        if ({c_rv[4], c_rdata[4]} !== {1'b1, 32'h000011AA}) begin
            bad++; $display("FAIL wrap_data got rv=%b data=%h want 1 000011aa", c_rv[4], c_rdata[4]);
        end
    endtask

    task automatic test_aligned_store;
        do_req(0, 1, 32'h8, 2'd2, 0, 32'h12345678);
        total++;
        if ({c_mrdy[1], c_we[1], c_addr[1], c_wstrb[1], c_wdata[1]} !== {2'b11, 30'h2, 4'hF, 32'h12345678}) begin
            bad++; $display("FAIL ast_beat got rdy=%b we=%b addr=%h strb=%h wd=%h", c_mrdy[1], c_we[1], c_addr[1], c_wstrb[1], c_wdata[1]);
        end
        total++;
        if ({c_mrdy[2], c_rv[2], c_err[2], c_rdy[2], c_rdata[2], c_rv[3]} !== {4'b0101, 32'h0, 1'b0}) begin
            bad++; $display("FAIL ast_resp got mrdy=%b rv=%b err=%b rdy=%b data=%h rv3=%b", c_mrdy[2], c_rv[2], c_err[2], c_rdy[2], c_rdata[2], c_rv[3]);
        end
    endtask

    task automatic test_split_store;
        do_req(0, 1, 32'h3, 2'd1, 0, 32'h0000BEEF);
        total++;
        if ({c_mrdy[1], c_we[1], c_addr[1], c_wstrb[1], c_wdata[1]} !== {2'b11, 30'h0, 4'b1000, 32'hEF000000}) begin
            bad++; $display("FAIL sst_beat1 got rdy=%b we=%b addr=%h strb=%b wd=%h", c_mrdy[1], c_we[1], c_addr[1], c_wstrb[1], c_wdata[1]);
        end
        total++;
        if ({c_mrdy[2], c_we[2], c_addr[2], c_wstrb[2], c_wdata[2]} !== {2'b11, 30'h1, 4'b0001, 32'h000000BE}) begin
            bad++; $display("FAIL sst_beat2 got rdy=%b we=%b addr=%h strb=%b wd=%h", c_mrdy[2], c_we[2], c_addr[2], c_wstrb[2], c_wdata[2]);
        end
        total++;
        if ({c_rv[2], c_rv[3], c_mrdy[3]} !== 3'b010) begin
            bad++; $display("FAIL sst_resp got rv2=%b rv3=%b mrdy3=%b want 0 1 0", c_rv[2], c_rv[3], c_mrdy[3]);
        end
        do_req(0, 0, 32'h0, 2'd2, 0, 32'h0);
        total++;
        if (c_rdata[3] !== 32'hEF332211) begin
            bad++; $display("FAIL sst_rb0 got %h want ef332211", c_rdata[3]);
        end
        do_req(0, 0, 32'h4, 2'd2, 0, 32'h0);
        total++;
        if (c_rdata[3] !== 32'h887766BE) begin
            bad++; $display("FAIL sst_rb1 got %h want 887766be", c_rdata[3]);
        end
        do_req(0, 0, 32'h8, 2'd2, 0, 32'h0);
        total++;
        if (c_rdata[3] !== 32'h12345678) begin
            bad++; $display("FAIL ast_rb got %h want 12345678", c_rdata[3]);
        end
    endtask

    task automatic test_misalign_reject;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) do_req(1, 0, 32'h1, 2'd2, 0, 32'h0);
            else        do_req(1, 1, 32'h3, 2'd1, 0, 32'h0000BEEF);
            total++;
            if ({c_rvb[1], c_errb[1], c_rdatab[1], c_rvb[2], c_errb[2]} !== {2'b11, 32'h0, 2'b00}) begin
                bad++; $display("FAIL rej_resp%0d got rv=%b err=%b data=%h rv2=%b err2=%b", t, c_rvb[1], c_errb[1], c_rdatab[1], c_rvb[2], c_errb[2]);
            end
            for (int k = 1; k <= 10; k++) begin
                total++;
                if (c_mrdyb[k] !== 1'b0) begin
                    bad++; $display("FAIL rej_nobeat%0d cycle %0d got mem_ready=%b want 0", t, k, c_mrdyb[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'hC; req_size = 2'd2; req_signed = 1'b0; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        total++;
        if ({req_ready, mem_ready, mem_we} !== 3'b011) begin
            bad++; $display("FAIL b2b_t1 got rdy=%b mrdy=%b we=%b want 0 1 1", req_ready, mem_ready, mem_we);
        end
        @(negedge clk);
        total++;
        if ({resp_valid, req_ready} !== 2'b11) begin
            bad++; $display("FAIL b2b_t2 got rv=%b rdy=%b want 1 1", resp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_ready, mem_we, mem_addr} !== {2'b10, 30'h3}) begin
            bad++; $display("FAIL b2b_beat got mrdy=%b we=%b addr=%h want 1 0 3", mem_ready, mem_we, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            bad++; $display("FAIL b2b_resp got rv=%b data=%h want 1 cafef00d", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_reset_midop;
        int pulses;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h2; req_size = 2'd2; req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        resetb = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err, mem_ready, mem_we} !== 5'b10000) begin
            bad++; $display("FAIL rst_mid_ctrl got=%b want=10000", {req_ready, resp_valid, resp_err, mem_ready, mem_we});
        end
        total++;
        if ({resp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 98'b0) begin
            bad++; $display("FAIL rst_mid_data got rdata=%h addr=%h wdata=%h wstrb=%h", resp_rdata, mem_addr, mem_wdata, mem_wstrb);
        end
        resetb = 1'b1;
        @(negedge clk);
        extra_rresp = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_ready got %b want 1", req_ready);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            extra_rresp = 1'b0;
            if (resp_valid === 1'b1 || mem_ready === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL rst_mid_quiet got %0d activity cycles want 0", pulses);
        end
        do_req(0, 0, 32'h0, 2'd2, 0, 32'h0);
        total++;
        if ({c_mrdy[1], c_rv[3], c_rdata[3]} !== {2'b11, 32'hEF332211}) begin
            bad++; $display("FAIL rst_mid_next got mrdy=%b rv=%b data=%h want 1 1 ef332211", c_mrdy[1], c_rv[3], c_rdata[3]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset;
        test_aligned_load;
        test_byte_half_load;
        test_split_load;
        test_addr_wrap;
        test_aligned_store;
        test_split_store;
        test_misalign_reject;
        test_back_to_back;
        test_reset_midop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
